// File: rtl/gate_sweep_ctrl_if.sv
// Capture-record stream from gate_sweep_ctrl (master) to the result consumer (slave).
interface gate_sweep_ctrl_if #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 2
);
   logic             cap_valid;
   logic             cap_ready;
   logic [N_IN-1:0]  cap_addr;
   logic [N_OUT-1:0] cap_data;
   logic             cap_mismatch;

   modport master (output cap_valid, cap_addr, cap_data, cap_mismatch, input cap_ready);
   modport slave  (input cap_valid, cap_addr, cap_data, cap_mismatch, output cap_ready);
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive, back-pressurable sweep of a combinational gate block with registered capture.
// Define GATE_SWEEP_CHECK_EN to add the expected-response table and mismatch counting.
module gate_sweep_ctrl #(
   parameter int N_IN        = 4,
   parameter int N_OUT       = 2,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic [N_IN-1:0]       dut_in,
   input  logic [N_OUT-1:0]      dut_out,
   gate_sweep_ctrl_if.master     cap,
   output logic [N_IN:0]         err_count,
   input  logic                  exp_wr_en,
   input  logic [N_IN-1:0]       exp_wr_addr,
   input  logic [N_OUT-1:0]      exp_wr_data
);

   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_e;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_e           state_q, state_d;
   logic [N_IN-1:0]  idx_q, idx_d;
   logic [7:0]       hold_q, hold_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cap_valid_q, cap_valid_d;
   logic [N_IN-1:0]  cap_addr_q, cap_addr_d;
   logic [N_OUT-1:0] cap_data_q, cap_data_d;
   logic             cap_mismatch_q, cap_mismatch_d;
   logic [N_IN:0]    err_q, err_d;
   logic             sample_mismatch;

`ifdef GATE_SWEEP_CHECK_EN
   logic [N_OUT-1:0] exp_q [2**N_IN];
   logic [N_OUT-1:0] exp_d [2**N_IN];

   always_comb begin
      exp_d = exp_q;
      if (exp_wr_en && state_q == IDLE) exp_d[exp_wr_addr] = exp_wr_data;
   end

   // NOTE: the table is small and must read as zero after reset, so it is built from
   // resettable flops rather than an inferred RAM, which could not be cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2**N_IN; i++) exp_q[i] <= '0;
      end else begin
         exp_q <= exp_d;
      end
   end

   assign sample_mismatch = (dut_out != exp_q[idx_q]);
`else
   logic unused_exp_wr;
   assign unused_exp_wr   = ^{exp_wr_en, exp_wr_addr, exp_wr_data};
   assign sample_mismatch = 1'b0;
`endif

   // NOTE: every _d signal takes its hold value first, so no path through the case leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      hold_d         = hold_q;
      done_d         = 1'b0;
      cap_valid_d    = cap_valid_q;
      cap_addr_d     = cap_addr_q;
      cap_data_d     = cap_data_q;
      cap_mismatch_d = cap_mismatch_q;
      err_d          = err_q;

      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = SETTLE;
               idx_d   = '0;
               hold_d  = '0;
               err_d   = '0;
            end
         end
         SETTLE: begin
            if (hold_q == HOLD_LAST) begin
               cap_data_d     = dut_out;
               cap_addr_d     = idx_q;
               cap_mismatch_d = sample_mismatch;
               cap_valid_d    = 1'b1;
               state_d        = CAPTURE;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         CAPTURE: begin
            if (cap.cap_ready) begin
               cap_valid_d = 1'b0;
               if (cap_mismatch_q) err_d = err_q + (N_IN+1)'(1);
               if (&idx_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = idx_q + N_IN'(1);
                  hold_d  = '0;
                  state_d = SETTLE;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Cancel overrides everything above, including a same-cycle handshake.
      if (abort && state_q != IDLE) begin
         state_d     = IDLE;
         idx_d       = '0;
         cap_valid_d = 1'b0;
         done_d      = 1'b0;
         err_d       = err_q;
      end
   end

   assign busy_d = (state_d != IDLE);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         idx_q          <= '0;
         hold_q         <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         cap_valid_q    <= 1'b0;
         cap_addr_q     <= '0;
         cap_data_q     <= '0;
         cap_mismatch_q <= 1'b0;
         err_q          <= '0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         hold_q         <= hold_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         cap_valid_q    <= cap_valid_d;
         cap_addr_q     <= cap_addr_d;
         cap_data_q     <= cap_data_d;
         cap_mismatch_q <= cap_mismatch_d;
         err_q          <= err_d;
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign dut_in           = idx_q;
   assign err_count        = err_q;
   assign cap.cap_valid    = cap_valid_q;
   assign cap.cap_addr     = cap_addr_q;
   assign cap.cap_data     = cap_data_q;
   assign cap.cap_mismatch = cap_mismatch_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: random gate truth tables and stalls against a
// timing/record model derived from the sweep rules.
module tb_gate_sweep_ctrl;
   localparam int N_IN  = 4;
   localparam int N_OUT = 2;
   localparam int HOLD  = 2;
   localparam int NV    = 2**N_IN;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             busy, done;
   logic [N_IN-1:0]  dut_in;
   logic [N_OUT-1:0] dut_out;
   logic [N_IN:0]    err_count;
   logic             exp_wr_en = 1'b0;
   logic [N_IN-1:0]  exp_wr_addr = '0;
   logic [N_OUT-1:0] exp_wr_data = '0;

   logic [N_OUT-1:0] tt    [NV];
   logic [N_OUT-1:0] tab_m [NV];
   int               stall [NV];
   int               n_pass = 0, n_fail = 0, n_total = 0;

   gate_sweep_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT)) cap_if ();

   gate_sweep_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .HOLD_CYCLES(HOLD)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
      .dut_in(dut_in), .dut_out(dut_out), .cap(cap_if), .err_count(err_count),
      .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data)
   );

   always #5 clk = ~clk;
   assign dut_out = tt[dut_in];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic ref_mis(input int k);
`ifdef GATE_SWEEP_CHECK_EN
      return tab_m[k] != tt[k];
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_reset(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_valid"}, cap_if.cap_valid, 0);
      check({tag, "_mis"}, cap_if.cap_mismatch, 0);
      check({tag, "_dut_in"}, dut_in, 0);
      check({tag, "_addr"}, cap_if.cap_addr, 0);
      check({tag, "_data"}, cap_if.cap_data, 0);
      check({tag, "_err"}, err_count, 0);
   endtask

   task automatic write_tab(input int a, input logic [N_OUT-1:0] d);
      exp_wr_en = 1'b1; exp_wr_addr = N_IN'(a); exp_wr_data = d;
      tick();
      exp_wr_en = 1'b0;
      tab_m[a] = d;
   endtask

   // One full sweep: stall[k] cycles of back-pressure on record k; poke drives start and
   // table writes throughout, all of which must be ignored while busy.
   task automatic run_sweep(input string tag, input bit poke);
      logic [N_IN-1:0]  r_addr [$];
      logic [N_OUT-1:0] r_data [$];
      logic             r_mis  [$];
      int               r_edge [$];
      int e = 0, k = 0, left, done_n = 0, done_e = -1, idle_e = -1, exp_edge = 0, n_mis = 0;
      bit hs;
      start = 1'b1; tick(); start = 1'b0;
      check({tag, "_busy_rise"}, busy, 1);
      left = stall[0];
      while (busy && e < 400) begin
         if (cap_if.cap_valid && left > 0) begin
            cap_if.cap_ready = 1'b0;
            check({tag, "_stall_addr"}, cap_if.cap_addr, k);
            check({tag, "_stall_data"}, cap_if.cap_data, tt[k]);
            check({tag, "_stall_dut_in"}, dut_in, k);
            left--;
         end else begin
            cap_if.cap_ready = 1'b1;
         end
         hs = cap_if.cap_valid && cap_if.cap_ready;
         if (hs) begin
            r_addr.push_back(cap_if.cap_addr);
            r_data.push_back(cap_if.cap_data);
            r_mis.push_back(cap_if.cap_mismatch);
            r_edge.push_back(e + 1);
         end
         if (poke) begin
            start = 1'($urandom_range(0, 1));
            exp_wr_en = 1'b1;
            exp_wr_addr = N_IN'($urandom_range(0, NV - 1));
            exp_wr_data = N_OUT'($urandom_range(0, 3));
         end
         tick();
         e++;
         start = 1'b0;
         exp_wr_en = 1'b0;
         if (hs) begin
            k++;
            if (k < NV) left = stall[k];
         end
         if (done) begin
            done_n++;
            done_e = e;
         end
      end
      if (!busy) idle_e = e;
      check({tag, "_timeout"}, busy, 0);
      check({tag, "_n_records"}, r_addr.size(), NV);
      for (int j = 0; j < NV; j++) begin
         exp_edge += HOLD + 1 + stall[j];
         if (ref_mis(j)) n_mis++;
         if (j < r_addr.size()) begin
            check($sformatf("%s_addr%0d", tag, j), r_addr[j], j);
            check($sformatf("%s_data%0d", tag, j), r_data[j], tt[j]);
            check($sformatf("%s_mis%0d", tag, j), r_mis[j], ref_mis(j));
            check($sformatf("%s_edge%0d", tag, j), r_edge[j], exp_edge);
         end
      end
      check({tag, "_done_count"}, done_n, 1);
      check({tag, "_done_edge"}, done_e, exp_edge);
      check({tag, "_idle_edge"}, idle_e, exp_edge + 1);
      check({tag, "_err_count"}, err_count, n_mis);
      check({tag, "_dut_in_kept"}, dut_in, NV - 1);
      cap_if.cap_ready = 1'b1;
   endtask

   initial begin
      int n, seen_done, exp_err;
      cap_if.cap_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         tt[i] = N_OUT'($urandom_range(0, 3));
         tab_m[i] = '0;
         stall[i] = 0;
      end
      #12;
      check_reset("reset");
      #6 rst = 1'b0;
      tick();

      // Default sweep, no back-pressure: final handshake at edge 48, done in cycle 49.
      run_sweep("plain", 1'b0);

      // Expected table = model with entries 2 and 9 corrupted; 5-cycle stall on record 7.
      for (int i = 0; i < NV; i++) write_tab(i, tt[i]);
      write_tab(2, ~tt[2]);
      write_tab(9, tt[9] ^ 2'b01);
      stall[7] = 5;
      run_sweep("stall7", 1'b0);
      stall[7] = 0;

      // Random back-pressure with start and table writes hammered while busy.
      for (int i = 0; i < NV; i++) stall[i] = $urandom_range(0, 3);
      run_sweep("poke", 1'b1);
      for (int i = 0; i < NV; i++) stall[i] = 0;

      // start and abort together in IDLE: abort wins.
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      check("start_abort_idle_busy", busy, 0);

      // Abort during SETTLE of vector 3.
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (!(dut_in == 3 && !cap_if.cap_valid) && n < 100) begin tick(); n++; end
      check("abort_reach_v3", dut_in, 3);
      exp_err = 0;
      for (int i = 0; i < 3; i++) if (ref_mis(i)) exp_err++;
      abort = 1'b1; tick(); abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_dut_in", dut_in, 0);
      check("abort_valid", cap_if.cap_valid, 0);
      check("abort_err_kept", err_count, exp_err);
      seen_done = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) seen_done++;
         tick();
      end
      check("abort_no_done", seen_done, 0);
      run_sweep("restart", 1'b0);

      // Reset asserted mid-CAPTURE must clear outputs before the next edge.
      start = 1'b1; tick(); start = 1'b0;
      cap_if.cap_ready = 1'b0;
      n = 0;
      while (!cap_if.cap_valid && n < 20) begin tick(); n++; end
      check("midcap_valid", cap_if.cap_valid, 1);
      tick();
      #2 rst = 1'b1;
      #1 check_reset("midcap_rst");
      #2 rst = 1'b0;
      for (int i = 0; i < NV; i++) tab_m[i] = '0;
      cap_if.cap_ready = 1'b1;
      tick();
      for (int i = 0; i < NV; i++) tt[i] = N_OUT'($urandom_range(0, 3));
      run_sweep("after_rst", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
